seq_restoring_divider: RTL

Multi-cycle unsigned restoring divider for the matrix-multiplication datapath. It is the inverse counterpart of the ripple-carry adder/accumulate path: it divides an accumulated value back down, for example for normalisation or averaging. Each cycle it performs one shift-and-subtract with a W+1-bit ripple subtract and produces one quotient bit, MSB first. Operands and results move over a start/ready/done handshake.

---
 rtl/seq_restoring_divider.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle, MSB first.
// Start/ready/done handshake; results held until the next accepted start.
module seq_restoring_divider #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  res_q, res_d;
  logic          dbz_q, dbz_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W:0]    t;
  logic [W:0]    d;
  logic          qbit;
  logic [W-1:0]  rem_nx;
  logic [W-1:0]  sh_nx;

  // sh holds the dividend; quotient bits fill in from the LSB as it drains
  assign t      = {rem_q, sh_q[W-1]};
  assign d      = t - {1'b0, dvs_q};
  assign qbit   = ~d[W];
  assign rem_nx = qbit ? d[W-1:0] : t[W-1:0];
  assign sh_nx  = {sh_q[W-2:0], qbit};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d   = '1;
            res_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            sh_d    = dividend;
            dvs_d   = divisor;
            rem_d   = '0;
            cnt_d   = CW'(W);
            quo_d   = '0;
            res_d   = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        rem_d = rem_nx;
        sh_d  = sh_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d   = sh_nx;
          res_d   = rem_nx;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sh_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready       = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = res_q;
  assign div_by_zero = dbz_q;

endmodule
